muldiv_ctrl: RTL and testbench

- Sequencer for the iterative multiply/divide unit that owns HI/LO.
- Accepts a mult/div op issued from EX and runs the shared datapath for a fixed number of iterations.
- Generates the datapath control strobes and the HI/LO write enable.
- Raises a stall request that the pipeline hazard logic ORs into its load-use stall: hold PC and IF/ID, bubble ID/EX.

---
 rtl/muldiv_ctrl_pkg.sv | 16 +
 rtl/muldiv_ctrl_md_iter_counter.sv | 19 +
 rtl/muldiv_ctrl.sv | 67 ++++++
 tb/tb_muldiv_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared state encoding, op codes and iteration defaults for the mult/div unit
package muldiv_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} md_state_t;
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;
  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction
  function automatic logic op_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction
endpackage

// File: rtl/muldiv_ctrl_md_iter_counter.sv
// md_iter_counter: loadable down-counter with terminal-count flag at 1
module md_iter_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  // load wins over decrement; decrement saturates at zero so the count never wraps
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign tc = cnt == W'(1);
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: mult/div sequencer owning HI/LO write timing; optional MULDIV_DIV0_SKIP_EN skips divide-by-zero
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       EX_MD_Start,
  input  logic [1:0] EX_MD_Op,
  input  logic       EX_Divisor_Zero,
  input  logic       ID_Uses_HiLo,
  output logic       MD_Load,
  output logic       MD_Step,
  output logic       MD_Signed,
  output logic       MD_IsDiv,
  output logic       HiLo_Wen,
  output logic       MD_Busy,
  output logic       MD_Stall
);
  md_state_t state, state_n;
  logic accept, skip, skip_q, tc;
  logic [CNT_W-1:0] load_val;
  assign accept = EX_MD_Start && (state == IDLE || state == DONE);
`ifdef MULDIV_DIV0_SKIP_EN
  assign skip = op_is_div(EX_MD_Op) && EX_Divisor_Zero;
`else
  logic unused_div0;
  assign unused_div0 = EX_Divisor_Zero;
  assign skip = 1'b0;
`endif
  assign load_val = op_is_div(EX_MD_Op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
  md_iter_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .dec      (MD_Step),
    .load_val (load_val),
    .tc       (tc)
  );
  // state register plus op attributes latched on accept
  always_ff @(posedge clk)
    if (reset) begin
      state     <= IDLE;
      MD_Signed <= 1'b0;
      MD_IsDiv  <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        MD_Signed <= op_is_signed(EX_MD_Op);
        MD_IsDiv  <= op_is_div(EX_MD_Op);
        skip_q    <= skip;
      end
    end
  // next state and strobes; a start seen during RUN is ignored
  always_comb begin
    state_n  = accept ? (skip ? DONE : RUN) : state == RUN ? (tc ? DONE : RUN) : IDLE;
    MD_Load  = accept;
    MD_Step  = state == RUN;
    HiLo_Wen = state == DONE && !skip_q;
    MD_Busy  = state != IDLE;
    MD_Stall = ID_Uses_HiLo && (state == RUN || accept);
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed plus random checks of muldiv_ctrl against a cycle-count reference model
module tb_muldiv_ctrl;
  localparam int MUL_N = 4;
  localparam int DIV_N = 32;
  logic clk = 1'b0, reset = 1'b0;
  logic EX_MD_Start = 1'b0, EX_Divisor_Zero = 1'b0, ID_Uses_HiLo = 1'b0;
  logic [1:0] EX_MD_Op = 2'b00;
  logic MD_Load, MD_Step, MD_Signed, MD_IsDiv, HiLo_Wen, MD_Busy, MD_Stall;
  int n_chk = 0, n_err = 0, cyc = 0;
  int m_active = 0, m_k = 0, m_n = 0, m_skip = 0;
  logic m_sgn = 1'b0, m_div = 1'b0;
  int n_steps = 0, n_wen = 0;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .EX_MD_Start(EX_MD_Start), .EX_MD_Op(EX_MD_Op),
    .EX_Divisor_Zero(EX_Divisor_Zero), .ID_Uses_HiLo(ID_Uses_HiLo),
    .MD_Load(MD_Load), .MD_Step(MD_Step), .MD_Signed(MD_Signed), .MD_IsDiv(MD_IsDiv),
    .HiLo_Wen(HiLo_Wen), .MD_Busy(MD_Busy), .MD_Stall(MD_Stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_chk++;
    assert (got == exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // one clock: drive inputs, check outputs mid-cycle, then advance the model at the edge
  task automatic tick(input logic s, input logic [1:0] o, input logic dz, input logic u, input logic r);
    bit in_run, in_done, acc, skip;
    EX_MD_Start = s; EX_MD_Op = o; EX_Divisor_Zero = dz; ID_Uses_HiLo = u; reset = r;
    in_run  = m_active != 0 && m_k >= 1 && m_k <= m_n;
    in_done = m_active != 0 && m_k == m_n + 1;
    acc = s && !in_run;
`ifdef MULDIV_DIV0_SKIP_EN
    skip = o[1] && dz;
`else
    skip = 1'b0;
`endif
    @(negedge clk);
    chk("load",   MD_Load,   acc);
    chk("step",   MD_Step,   in_run);
    chk("wen",    HiLo_Wen,  in_done && m_skip == 0);
    chk("busy",   MD_Busy,   in_run || in_done);
    chk("stall",  MD_Stall,  u && (in_run || acc));
    chk("signed", MD_Signed, m_sgn);
    chk("isdiv",  MD_IsDiv,  m_div);
    n_steps += int'(MD_Step);
    n_wen   += int'(HiLo_Wen);
    @(posedge clk);
    cyc++;
    if (r) begin
      m_active = 0; m_sgn = 1'b0; m_div = 1'b0; m_skip = 0;
    end else if (acc) begin
      m_active = 1; m_k = 1; m_skip = int'(skip);
      m_n = skip ? 0 : (o[1] ? DIV_N : MUL_N);
      m_sgn = !o[0]; m_div = o[1];
    end else if (in_done) m_active = 0;
    else if (m_active != 0) m_k++;
    #1;
  endtask

  task automatic idle(input int n, input logic u);
    for (int i = 0; i < n; i++) tick(1'b0, 2'b00, 1'b0, u, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5, 1'b0);
    n_steps = 0; n_wen = 0;
    tick(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(7, 1'b0);
    chk_int("mult_steps", n_steps, MUL_N);
    chk_int("mult_wen", n_wen, 1);
    tick(1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
    idle(35, 1'b1);
    idle(2, 1'b0);
    tick(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    tick(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(7, 1'b0);
    n_steps = 0; n_wen = 0;
    tick(1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
    idle(9, 1'b1);
    tick(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
    idle(4, 1'b1);
    chk_int("rst_wen", n_wen, 0);
    n_steps = 0; n_wen = 0;
    tick(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    idle(36, 1'b0);
`ifdef MULDIV_DIV0_SKIP_EN
    chk_int("div0_steps", n_steps, 0);
    chk_int("div0_wen", n_wen, 0);
`else
    chk_int("div0_steps", n_steps, DIV_N);
    chk_int("div0_wen", n_wen, 1);
`endif
    tick(1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
    idle(6, 1'b1);
    for (int i = 0; i < 1500; i++)
      tick($urandom_range(3) == 0, 2'($urandom), $urandom_range(1) == 0,
           $urandom_range(1) == 0, $urandom_range(63) == 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
